// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down_counter_timer block.
//   state_e        : two-state control FSM (IDLE / RUN), 1-bit encoding
//   DEFAULT_WIDTH  : default counter / load-data width
//   DEC_ONE        : step size subtracted by the decrementer each enabled edge
package down_counter_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEC_ONE       = 1;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer_counter_dec.sv
// Combinational WIDTH-bit subtract-by-one; the decrementing counterpart of
// the adder used by the up-counter.
//   a : value to decrement
//   y : a - 1 (wraps modulo 2^WIDTH; the caller never applies it at zero)
module counter_dec
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a - WIDTH'(DEC_ONE);
    end

endmodule : counter_dec

// File: rtl/down_counter_timer.sv
// Loadable, enable-gated down-counter with a one-cycle terminal-count pulse
// and optional auto-reload. Used as an interval timer / prescaler.
//   CLK       : clock, rising edge
//   RESET     : asynchronous reset, active-low
//   LOAD      : load strobe; captures D into the count and reload registers
//   D         : load value
//   EN        : count enable; one step per enabled edge while running
//   RELOAD_EN : at the terminal edge, 1 = restart from last load, 0 = stop
//   O         : current count (registered)
//   TC        : terminal-count pulse, one cycle (registered)
//   BUSY      : high while the FSM is in RUN (registered)
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             RELOAD_EN,
    output logic [WIDTH-1:0] O,
    output logic             TC,
    output logic             BUSY
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] cnt_dec;

    counter_dec #(
        .WIDTH(WIDTH)
    ) u_dec (
        .a(cnt_q),
        .y(cnt_dec)
    );

    // Priority: LOAD, then terminal event, then decrement, then hold.
    // The decrement result is only selected when the count is non-zero,
    // so the count never wraps to all-ones.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;

        if (LOAD) begin
            cnt_d   = D;
            rld_d   = D;
            state_d = (D != '0) ? RUN : IDLE;
        end else if (state_q == RUN && EN) begin
            if (cnt_q == '0) begin
                tc_d = 1'b1;
                if (RELOAD_EN) begin
                    cnt_d = rld_q;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                cnt_d = cnt_dec;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    assign O    = cnt_q;
    assign TC   = tc_q;
    assign BUSY = (state_q == RUN);

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

    localparam int unsigned W = 4;

    logic         CLK;
    logic         RESET;
    logic         LOAD;
    logic [W-1:0] D;
    logic         EN;
    logic         RELOAD_EN;
    logic [W-1:0] O;
    logic         TC;
    logic         BUSY;

    int checks = 0;
    int errors = 0;

    // Reference model: a timer that is either running or stopped, with the
    // number of enabled edges left before it fires, and the period it restarts with.
    int m_o;
    int m_rld;
    bit m_run;
    bit m_tc;

    down_counter_timer #(
        .WIDTH(W)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .LOAD(LOAD),
        .D(D),
        .EN(EN),
        .RELOAD_EN(RELOAD_EN),
        .O(O),
        .TC(TC),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_o = 0; m_rld = 0; m_run = 0; m_tc = 0;
    endtask

    task automatic model_edge(input bit ld, input int dv, input bit en, input bit rel);
        m_tc = 0;
        if (ld) begin
            m_o   = dv % (1 << W);
            m_rld = m_o;
            m_run = (m_o != 0);
        end else if (m_run && en) begin
            if (m_o > 0) begin
                m_o = m_o - 1;
            end else begin
                m_tc = 1;
                if (rel) m_o = m_rld;
                else     m_run = 0;
            end
        end
    endtask

    // Apply inputs, take one rising edge, advance the model, settle.
    task automatic step(input bit ld, input int dv, input bit en, input bit rel);
        LOAD = ld; D = W'(dv); EN = en; RELOAD_EN = rel;
        @(posedge CLK);
        model_edge(ld, dv, en, rel);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; LOAD = 0; D = '0; EN = 0; RELOAD_EN = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({O, TC, BUSY} !== {W'(m_o), m_tc, m_run}) begin
            errors++;
            $display("FAIL reset_initial: got O=%0d TC=%0b BUSY=%0b want O=%0d TC=%0b BUSY=%0b",
                     O, TC, BUSY, m_o, m_tc, m_run);
        end
        RESET = 1'b1;
        step(1, 9, 1, 0);
        for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 0);
        checks++;
        if (O !== W'(5)) begin
            errors++;
            $display("FAIL reset_precount: got O=%0d want O=5", O);
        end
        #2 RESET = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({O, TC, BUSY} !== {W'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got O=%0d TC=%0b BUSY=%0b want O=0 TC=0 BUSY=0", O, TC, BUSY);
        end
        #2 RESET = 1'b1;
        for (int unsigned i = 0; i < 12; i++) begin
            step(0, 0, 1, 0);
            checks++;
            if ({O, TC, BUSY} !== {W'(0), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_after: got O=%0d TC=%0b BUSY=%0b want O=0 TC=0 BUSY=0", O, TC, BUSY);
            end
        end
    endtask

    task automatic test_one_shot();
        int tc_count = 0;
        int exp_o[6] = '{3, 2, 1, 0, 0, 0};
        bit exp_tc[6] = '{0, 0, 0, 0, 1, 0};
        bit exp_b[6]  = '{1, 1, 1, 1, 0, 0};
        for (int unsigned i = 0; i < 6; i++) begin
            step(i == 0, 3, 1, 0);
            tc_count += int'(TC);
            checks++;
            if ({O, TC, BUSY} !== {W'(exp_o[i]), exp_tc[i], exp_b[i]}) begin
                errors++;
                $display("FAIL one_shot[%0d]: got O=%0d TC=%0b BUSY=%0b want O=%0d TC=%0b BUSY=%0b",
                         i, O, TC, BUSY, exp_o[i], exp_tc[i], exp_b[i]);
            end
        end
        checks++;
        if (tc_count != 1) begin
            errors++;
            $display("FAIL one_shot_tc_count: got %0d want 1", tc_count);
        end
    endtask

    task automatic test_auto_reload();
        int tc_count = 0;
        step(1, 2, 1, 1);
        for (int unsigned i = 1; i <= 12; i++) begin
            step(0, 0, 1, 1);
            tc_count += int'(TC);
            checks++;
            if ({O, TC, BUSY} !== {W'(m_o), m_tc, m_run} || TC !== (i % 3 == 0) || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL auto_reload[%0d]: got O=%0d TC=%0b BUSY=%0b want O=%0d TC=%0b BUSY=1",
                         i, O, TC, BUSY, m_o, m_tc);
            end
        end
        checks++;
        if (tc_count != 4) begin
            errors++;
            $display("FAIL auto_reload_tc_count: got %0d want 4", tc_count);
        end
    endtask

    task automatic test_enable_gating();
        bit pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
        step(1, 4, 1, 0);
        for (int unsigned i = 0; i < 8; i++) begin
            step(0, 0, pat[i], 0);
            checks++;
            if ({O, TC, BUSY} !== {W'(m_o), m_tc, m_run} || TC !== (i == 7)) begin
                errors++;
                $display("FAIL enable_gating[%0d]: got O=%0d TC=%0b BUSY=%0b want O=%0d TC=%0b BUSY=%0b",
                         i, O, TC, BUSY, m_o, m_tc, m_run);
            end
        end
    endtask

    task automatic test_collisions();
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        step(1, 6, 1, 0);
        checks++;
        if ({O, TC, BUSY} !== {W'(6), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_on_terminal: got O=%0d TC=%0b BUSY=%0b want O=6 TC=0 BUSY=1", O, TC, BUSY);
        end
        step(1, 0, 1, 1);
        for (int unsigned i = 0; i < 6; i++) begin
            checks++;
            if ({O, TC, BUSY} !== {W'(0), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL load_zero[%0d]: got O=%0d TC=%0b BUSY=%0b want O=0 TC=0 BUSY=0",
                         i, O, TC, BUSY);
            end
            step(0, 0, 1, 1);
        end
    endtask

    task automatic test_full_range();
        int tc_count = 0;
        int last_tc = 0;
        step(1, 15, 1, 1);
        for (int i = 1; i <= 48; i++) begin
            step(0, 0, 1, 1);
            checks++;
            if ({O, TC, BUSY} !== {W'(m_o), m_tc, m_run}) begin
                errors++;
                $display("FAIL full_range[%0d]: got O=%0d TC=%0b BUSY=%0b want O=%0d TC=%0b BUSY=%0b",
                         i, O, TC, BUSY, m_o, m_tc, m_run);
            end
            if (TC === 1'b1) begin
                tc_count++;
                checks++;
                if (i - last_tc != 16) begin
                    errors++;
                    $display("FAIL full_range_period: got %0d want 16", i - last_tc);
                end
                last_tc = i;
            end
        end
        checks++;
        if (tc_count != 3) begin
            errors++;
            $display("FAIL full_range_tc_count: got %0d want 3", tc_count);
        end
    endtask

    task automatic test_random();
        bit rel = 0;
        for (int unsigned i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) rel = ~rel;
            step($urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, rel);
            checks++;
            if ({O, TC, BUSY} !== {W'(m_o), m_tc, m_run}) begin
                errors++;
                $display("FAIL random[%0d]: got O=%0d TC=%0b BUSY=%0b want O=%0d TC=%0b BUSY=%0b",
                         i, O, TC, BUSY, m_o, m_tc, m_run);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_gating();
        test_collisions();
        test_full_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_down_counter_timer
